// File: rtl/seg7_scan_display.sv
// Scanned 8-digit common-anode driver for four 0..99 groups.
// Groups are snapshotted once per frame so a frame never tears.
module seg7_scan_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] grp0,
    input  logic [7:0] grp1,
    input  logic [7:0] grp2,
    input  logic [7:0] grp3,
    input  logic [1:0] sel,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] BLANK = 7'h7F;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick;
    logic            run_q;
    logic [2:0]      idx_q;
    logic [3:0][7:0] snap_q;
    logic            tick_q;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            ft_q;
    logic [7:0]      val;
    logic [7:0]      tens_w, ones_w;
    logic [3:0]      digit;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = DASH;
        endcase
        return s;
    endfunction

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        val    = snap_q[idx_q[2:1]];
        tens_w = val / 8'd10;
        ones_w = val % 8'd10;
        digit  = idx_q[0] ? tens_w[3:0] : ones_w[3:0];
        an_d   = ~(8'b1 << idx_q);
        dp_d   = (idx_q != {sel, 1'b0});
        if (val > 8'd99)
            seg_d = DASH;
        else if (LZ_BLANK && idx_q[0] && val < 8'd10)
            seg_d = BLANK;
        else
            seg_d = seg_code(digit);
    end

    // Outputs load one cycle after the tick, from the freshly advanced slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            idx_q  <= '0;
            snap_q <= '0;
            tick_q <= 1'b0;
            an_q   <= 8'hFF;
            seg_q  <= BLANK;
            dp_q   <= 1'b1;
            ft_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick;
            if (tick) begin
                if (!run_q || idx_q == 3'd7) begin
                    idx_q  <= '0;
                    run_q  <= 1'b1;
                    snap_q <= {grp3, grp2, grp1, grp0};
                end else begin
                    idx_q <= idx_q + 3'd1;
                end
            end
            if (tick_q) begin
                an_q  <= an_d;
                seg_q <= seg_d;
                dp_q  <= dp_d;
                ft_q  <= (idx_q == 3'd0);
            end else begin
                ft_q  <= 1'b0;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench: three instances cover plain, blanking and SCAN_DIV=1.
// Expected slots are queued when groups are driven and popped per slot.
module tb_seg7_scan_display;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ga[4], gb[4], gc[4];
    logic [1:0] sel_a, sel_b, sel_c;
    logic [7:0] an_a, an_b, an_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic       ft_a, ft_b, ft_c;
    logic       mon_a = 1'b0, mon_b = 1'b0;
    logic [7:0] prev_a, prev_b;
    exp_t       qa[$], qb[$];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .grp0(ga[0]), .grp1(ga[1]), .grp2(ga[2]), .grp3(ga[3]),
        .sel(sel_a), .an(an_a), .seg(seg_a), .dp(dp_a),
        .frame_tick(ft_a)
    );

    seg7_scan_display #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .grp0(gb[0]), .grp1(gb[1]), .grp2(gb[2]), .grp3(gb[3]),
        .sel(sel_b), .an(an_b), .seg(seg_b), .dp(dp_b),
        .frame_tick(ft_b)
    );

    seg7_scan_display #(.SCAN_DIV(1), .LZ_BLANK(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n),
        .grp0(gc[0]), .grp1(gc[1]), .grp2(gc[2]), .grp3(gc[3]),
        .sel(sel_c), .an(an_c), .seg(seg_c), .dp(dp_c),
        .frame_tick(ft_c)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic push_frame(input int which, input bit lz,
                              input logic [7:0] g0, input logic [7:0] g1,
                              input logic [7:0] g2, input logic [7:0] g3,
                              input int s);
        int   v[4];
        exp_t e;
        v = '{int'(g0), int'(g1), int'(g2), int'(g3)};
        for (int i = 0; i < 8; i++) begin
            int x;
            x = v[i / 2];
            e.an = 8'hFF;
            e.an[i] = 1'b0;
            if (x > 99)
                e.seg = 7'b0111111;
            else if (i % 2 == 1)
                e.seg = (lz && x <= 9) ? 7'h7F : seg_of(x / 10);
            else
                e.seg = seg_of(x % 10);
            e.dp = (i == 2 * s) ? 1'b0 : 1'b1;
            e.ft = (i == 0);
            if (which == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_a) begin
            if (an_a !== prev_a) begin
                chk("a_qnonempty", qa.size() != 0, 1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    chk("a_an", an_a, e.an);
                    chk("a_seg", seg_a, e.seg);
                    chk("a_dp", dp_a, e.dp);
                    chk("a_ft", ft_a, e.ft);
                end
            end else begin
                chk("a_ft_idle", ft_a, 0);
            end
        end
        prev_a <= an_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_b) begin
            if (an_b !== prev_b) begin
                chk("b_qnonempty", qb.size() != 0, 1);
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    chk("b_an", an_b, e.an);
                    chk("b_seg", seg_b, e.seg);
                    chk("b_dp", dp_b, e.dp);
                    chk("b_ft", ft_b, e.ft);
                end
            end else begin
                chk("b_ft_idle", ft_b, 0);
            end
        end
        prev_b <= an_b;
    end

    initial begin
        ga = '{8'd42, 8'd7, 8'd100, 8'd255};
        gb = '{8'd0, 8'd9, 8'd10, 8'd5};
        gc = '{8'd12, 8'd34, 8'd56, 8'd78};
        sel_a = 2'd0;
        sel_b = 2'd3;
        sel_c = 2'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", an_a, 8'hFF);
        chk("rst_seg", seg_a, 7'h7F);
        chk("rst_dp", dp_a, 1);
        chk("rst_ft", ft_a, 0);
        chk("rst_an_c", an_c, 8'hFF);
        push_frame(0, 1'b0, ga[0], ga[1], ga[2], ga[3], sel_a);
        push_frame(1, 1'b1, gb[0], gb[1], gb[2], gb[3], sel_b);
        @(negedge clk);
        mon_a = 1'b1;
        mon_b = 1'b1;
        rst_n = 1'b1;
        fork
            begin : seq_a
                bit found;
                repeat (4) @(posedge clk);
                #1;
                chk("a_c4_an", an_a, 8'hFF);
                @(posedge clk);
                #1;
                chk("a_c5_an", an_a, 8'hFE);
                chk("a_c5_seg", seg_a, 7'b0100100);
                chk("a_c5_dp", dp_a, 0);
                chk("a_c5_ft", ft_a, 1);
                found = 0;
                for (int i = 0; i < 50 && !found; i++) begin
                    @(negedge clk);
                    found = (an_a == 8'hFD);
                end
                chk("a_wait_fd", found, 1);
                ga[1] = 8'd58;
                push_frame(0, 1'b0, ga[0], ga[1], ga[2], ga[3], sel_a);
                for (int i = 0; i < 200 && qa.size() != 0; i++)
                    @(negedge clk);
                chk("a_drain", qa.size(), 0);
            end
            begin : seq_b
                bit found;
                found = 0;
                for (int i = 0; i < 50 && !found; i++) begin
                    @(negedge clk);
                    found = ft_b;
                end
                chk("b_wait_ft", found, 1);
                gb[3] = 8'd0;
                push_frame(1, 1'b1, gb[0], gb[1], gb[2], gb[3], sel_b);
                for (int i = 0; i < 200 && qb.size() != 0; i++)
                    @(negedge clk);
                chk("b_drain", qb.size(), 0);
            end
            begin : seq_c
                int last;
                int np;
                last = -1;
                np = 0;
                for (int cyc = 1; cyc <= 40; cyc++) begin
                    @(negedge clk);
                    chk("c_dp", dp_c, an_c != 8'hEF);
                    if (ft_c) begin
                        chk("c_ft_an", an_c, 8'hFE);
                        if (last >= 0) chk("c_gap", cyc - last, 8);
                        last = cyc;
                        np++;
                    end
                end
                chk("c_pulses", np, 5);
            end
        join
        mon_a = 1'b0;
        mon_b = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_an", an_a, 8'hFF);
        chk("mid_seg", seg_a, 7'h7F);
        chk("mid_dp", dp_a, 1);
        chk("mid_ft", ft_a, 0);
        chk("mid_an_c", an_c, 8'hFF);
        chk("mid_dp_c", dp_c, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
